// File: rtl/alu_serial_if.sv
// Handshake and operand/result bundle between decode, the serial ALU and writeback.
// Defining ALU_SERIAL_BONUS_CMP_EN adds the bonus_control compare-select field.
interface alu_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [3:0]       ALU_control;
`ifdef ALU_SERIAL_BONUS_CMP_EN
  logic [2:0]       bonus_control;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

`ifdef ALU_SERIAL_BONUS_CMP_EN
  modport master (
    output start, src1, src2, ALU_control, bonus_control,
    input  busy, done, result, zero, cout, overflow
  );
  modport slave (
    input  start, src1, src2, ALU_control, bonus_control,
    output busy, done, result, zero, cout, overflow
  );
`else
  modport master (
    output start, src1, src2, ALU_control,
    input  busy, done, result, zero, cout, overflow
  );
  modport slave (
    input  start, src1, src2, ALU_control,
    output busy, done, result, zero, cout, overflow
  );
`endif
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU: one 1-bit slice per clock, LSB first, with a registered carry between bits.
// Optional ALU_SERIAL_BONUS_CMP_EN turns opcode 0111 into a bonus_control-selected compare.
module alu_serial #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  alu_serial_if.slave bus
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {SEL_ZERO, SEL_AND, SEL_OR, SEL_SUM} sel_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, result_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             carry, zero_q, cout_q, overflow_q;
`ifdef ALU_SERIAL_BONUS_CMP_EN
  logic [2:0]       bonus_q;
  logic             sum_any;
  logic             eq_bit;
`endif

  logic             a_inv, b_inv, arith, ovf_en, is_cmp, init_carry;
  sel_t             sel;
  logic             a_bit, b_bit, sum_bit, carry_out, ovf_bit, lt_bit, slice_bit, cmp_bit;
  logic [WIDTH-1:0] shifted, final_result;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Slice controls come from the latched opcode; unknown codes produce all-zero results.
  always_comb begin
    a_inv  = 1'b0;
    b_inv  = 1'b0;
    arith  = 1'b0;
    ovf_en = 1'b0;
    is_cmp = 1'b0;
    sel    = SEL_ZERO;
    case (op_q)
      OP_AND: sel = SEL_AND;
      OP_OR:  sel = SEL_OR;
      OP_ADD: begin sel = SEL_SUM; arith = 1'b1; ovf_en = 1'b1; end
      OP_SUB: begin sel = SEL_SUM; b_inv = 1'b1; arith = 1'b1; ovf_en = 1'b1; end
      OP_NOR: begin sel = SEL_AND; a_inv = 1'b1; b_inv = 1'b1; end
      OP_SLT: begin b_inv = 1'b1; arith = 1'b1; is_cmp = 1'b1; end
      default: ;
    endcase
  end

  assign init_carry = (bus.ALU_control == OP_SUB) || (bus.ALU_control == OP_SLT);

  assign a_bit     = a_sh[0] ^ a_inv;
  assign b_bit     = b_sh[0] ^ b_inv;
  assign sum_bit   = a_bit ^ b_bit ^ carry;
  assign carry_out = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
  assign ovf_bit   = carry ^ carry_out;
  assign lt_bit    = sum_bit ^ ovf_bit;

  always_comb begin
    slice_bit = 1'b0;
    case (sel)
      SEL_AND: slice_bit = a_bit & b_bit;
      SEL_OR:  slice_bit = a_bit | b_bit;
      SEL_SUM: slice_bit = sum_bit;
      default: slice_bit = 1'b0;
    endcase
  end

`ifdef ALU_SERIAL_BONUS_CMP_EN
  // Equality needs every difference bit, so the MSB bit is folded in combinationally.
  assign eq_bit = ~(sum_any | sum_bit);

  always_comb begin
    cmp_bit = 1'b0;
    case (bonus_q)
      3'b000:  cmp_bit = lt_bit;
      3'b001:  cmp_bit = ~lt_bit & ~eq_bit;
      3'b010:  cmp_bit = lt_bit | eq_bit;
      3'b011:  cmp_bit = ~lt_bit;
      3'b110:  cmp_bit = eq_bit;
      3'b100:  cmp_bit = ~eq_bit;
      default: cmp_bit = 1'b0;
    endcase
  end
`else
  assign cmp_bit = lt_bit;
`endif

  assign shifted      = {slice_bit, result_q[WIDTH-1:1]};
  assign final_result = is_cmp ? {{(WIDTH-1){1'b0}}, cmp_bit} : shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      op_q       <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef ALU_SERIAL_BONUS_CMP_EN
      bonus_q    <= '0;
      sum_any    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.src1;
            b_sh  <= bus.src2;
            op_q  <= bus.ALU_control;
            carry <= init_carry;
            cnt   <= '0;
`ifdef ALU_SERIAL_BONUS_CMP_EN
            bonus_q <= bus.bonus_control;
            sum_any <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_out;
          cnt   <= cnt + CW'(1);
`ifdef ALU_SERIAL_BONUS_CMP_EN
          sum_any <= sum_any | sum_bit;
`endif
          // Flags are committed on the same edge as the final bit so they always match result.
          if (cnt == LAST) begin
            result_q   <= final_result;
            zero_q     <= (final_result == '0);
            cout_q     <= arith & carry_out;
            overflow_q <= ovf_en & ovf_bit;
          end else begin
            result_q <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial: directed vector table, multi-cycle corner sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu_serial;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         z;
    logic         c;
    logic         v;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_serial_if #(.WIDTH(W)) bus ();

  alu_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model written from the opcode definitions with plain arithmetic
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [2:0] bonus);
    exp_t       e;
    logic [W:0] wide;
    logic       lt, eq, bitv;
    e    = '0;
    wide = '0;
    lt   = ($signed(a) < $signed(b));
    eq   = (a == b);
    case (op)
      4'b0000: e.result = a & b;
      4'b0001: e.result = a | b;
      4'b1100: e.result = ~(a | b);
      4'b0010: begin
        wide     = {1'b0, a} + {1'b0, b};
        e.result = wide[W-1:0];
        e.cout   = wide[W];
        e.ovf    = (a[W-1] == b[W-1]) && (e.result[W-1] != a[W-1]);
      end
      4'b0110: begin
        wide     = {1'b0, a} + {1'b0, ~b} + 1;
        e.result = wide[W-1:0];
        e.cout   = wide[W];
        e.ovf    = (a[W-1] != b[W-1]) && (e.result[W-1] != a[W-1]);
      end
      4'b0111: begin
        wide   = {1'b0, a} + {1'b0, ~b} + 1;
        e.cout = wide[W];
        bitv   = lt;
`ifdef ALU_SERIAL_BONUS_CMP_EN
        case (bonus)
          3'b000:  bitv = lt;
          3'b001:  bitv = !lt && !eq;
          3'b010:  bitv = lt || eq;
          3'b011:  bitv = !lt;
          3'b110:  bitv = eq;
          3'b100:  bitv = !eq;
          default: bitv = 1'b0;
        endcase
`else
        bitv = lt & (eq | ~eq) & (bonus == bonus);
`endif
        e.result = {{(W-1){1'b0}}, bitv};
      end
      default: e.result = '0;
    endcase
    e.zero = (e.result == '0);
    return e;
  endfunction

  task automatic checkValue(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checkValue({name, "_result"}, bus.result, e.result);
    checkValue({name, "_zero"}, W'(bus.zero), W'(e.zero));
    checkValue({name, "_cout"}, W'(bus.cout), W'(e.cout));
    checkValue({name, "_overflow"}, W'(bus.overflow), W'(e.ovf));
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    checkValue("idle_timeout", W'(bus.busy), '0);
  endtask

  task automatic driveInputs(input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [2:0] bonus);
    bus.ALU_control = op;
    bus.src1        = a;
    bus.src2        = b;
`ifdef ALU_SERIAL_BONUS_CMP_EN
    bus.bonus_control = bonus;
`else
    if (bonus == 3'b111) bus.src2 = b;
`endif
  endtask

  // Accepts one operation, scrambles inputs during RUN, waits for done and reports its latency.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [2:0] bonus,
                               output int lat, output bit seen);
    waitIdle();
    driveInputs(op, a, b, bonus);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    driveInputs(4'($urandom), $urandom, $urandom, 3'($urandom));
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= W + 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        lat  = i;
        break;
      end
    end
  endtask

  task automatic runOp(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] bonus, input exp_t e);
    int lat;
    bit seen;
    applyStimulus(op, a, b, bonus, lat, seen);
    if (!seen) begin
      checkValue({name, "_done_timeout"}, '0, W'(1));
      return;
    end
    checkValue({name, "_latency"}, W'(lat), W'(W));
    checkOutput(name, e);
    @(posedge clk);
    #1;
    checkValue({name, "_done_pulse"}, W'(bus.done), '0);
    checkValue({name, "_result_hold"}, bus.result, e.result);
  endtask

  vec_t vecs[12];

  initial begin
    int        rises[$];
    int        dones;
    logic      prev;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [2:0] bonus;
    logic [W-1:0] specials[5];
    logic [3:0]   ops[7];
    exp_t         e;

    vecs[0]  = '{"add_ovf",   4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"sub_eq",    4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{"sub_ovf",   4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{"slt_true",  4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{"slt_false", 4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"nor",       4'b1100, 32'h0F0F0F0F, 32'hF0F00000, 32'h0000F0F0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"and",       4'b0000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"or",        4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"invalid",   4'b1111, 32'hABCD1234, 32'h00001234, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"add_wrap",  4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{"and_zero",  4'b0000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{"sub_neg",   4'b0110, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

    specials = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    ops      = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111, 4'b1111};

    rst       = 1'b1;
    bus.start = 1'b0;
    driveInputs(4'b0000, '0, '0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    checkValue("reset_busy", W'(bus.busy), '0);
    checkValue("reset_done", W'(bus.done), '0);
    checkOutput("reset", '{result: '0, zero: 1'b0, cout: 1'b0, ovf: 1'b0});
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      e = '{result: vecs[i].r, zero: vecs[i].z, cout: vecs[i].c, ovf: vecs[i].v};
      runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 3'b000, e);
    end

    // Abort mid-run: reset after ten bits must leave no done pulse and cleared outputs
    waitIdle();
    driveInputs(4'b0010, 32'h00001234, 32'h00000001, 3'b000);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkValue("abort_busy", W'(bus.busy), '0);
    checkValue("abort_done", W'(bus.done), '0);
    checkValue("abort_result", bus.result, '0);
    dones = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checkValue("abort_no_done", W'(dones), '0);
    runOp("after_abort", 4'b0010, 32'h00000010, 32'h00000020, 3'b000,
          model(4'b0010, 32'h10, 32'h20, 3'b000));

    // start held high continuously: accepts spaced by WIDTH+2 cycles
    waitIdle();
    driveInputs(4'b0010, 32'd3, 32'd4, 3'b000);
    bus.start = 1'b1;
    prev      = 1'b0;
    for (int i = 0; i < 2 * (W + 2) + 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy && !prev) rises.push_back(i);
      if (bus.done) checkValue("held_result", bus.result, 32'd7);
      prev = bus.busy;
    end
    bus.start = 1'b0;
    checkValue("held_accepts", W'(rises.size() >= 2), W'(1));
    if (rises.size() >= 2) checkValue("held_spacing", W'(rises[1] - rises[0]), W'(W + 2));

`ifdef ALU_SERIAL_BONUS_CMP_EN
    runOp("bonus_eq",  4'b0111, 32'h12345678, 32'h12345678, 3'b110, '{32'h1, 1'b0, 1'b1, 1'b0});
    runOp("bonus_ne",  4'b0111, 32'h12345678, 32'h12345678, 3'b100, '{32'h0, 1'b1, 1'b1, 1'b0});
    runOp("bonus_le",  4'b0111, 32'h12345678, 32'h12345678, 3'b010, '{32'h1, 1'b0, 1'b1, 1'b0});
    runOp("bonus_gt",  4'b0111, 32'h12345678, 32'h12345678, 3'b001, '{32'h0, 1'b1, 1'b1, 1'b0});
    runOp("bonus_gt2", 4'b0111, 32'h00000005, 32'hFFFFFFFF, 3'b001, '{32'h1, 1'b0, 1'b0, 1'b0});
`endif

    for (int i = 0; i < 40; i++) begin
      op    = ops[$urandom_range(0, 6)];
      if (op == 4'b1111) op = 4'($urandom);
      a     = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      b     = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : W'($urandom);
      bonus = 3'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
`ifdef ALU_SERIAL_BONUS_CMP_EN
      e = model(op, a, b, bonus);
`else
      e = model(op, a, b, 3'b000);
`endif
      runOp($sformatf("rand%0d_op%b_bonus%b", i, op, bonus), op, a, b, bonus, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
